// File: rtl/i2c_color_receiver_pkg.sv
// rtl/i2c_color_receiver_pkg.sv - shared colour link types, constants and word assembly
package colour_link_pkg;

   localparam int FRAME_BYTES = 10;
   localparam int WORDS       = FRAME_BYTES / 2;

   // Channel order on the wire; the transmitter uses the same numbering.
   localparam int CH_CLEAR    = 0;
   localparam int CH_RED      = 1;
   localparam int CH_GREEN    = 2;
   localparam int CH_BLUE     = 3;
   localparam int CH_INFRARED = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_DATA,
      ST_DATA_ACK,
      ST_WAIT_STOP,
      ST_IGNORE
   } rx_state_e;

   // endian=1: first byte on the wire is the high byte.
   function automatic logic [15:0] assemble_word(input logic [7:0] first_b,
                                                 input logic [7:0] second_b,
                                                 input logic       endian);
      return endian ? {first_b, second_b} : {second_b, first_b};
   endfunction

endpackage

// File: rtl/i2c_color_receiver_if.sv
// rtl/i2c_color_receiver_if.sv - pad-side I2C signals of the colour sensor link
interface i2c_color_receiver_if;
   logic scl;
   logic sda_in;
   logic sda_oe;

   modport master (output scl, output sda_in, input sda_oe);
   modport slave  (input scl, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_color_receiver_bus_monitor.sv
// rtl/i2c_color_receiver_bus_monitor.sv - SCL/SDA synchronisers with edge and START/STOP detection
module i2c_bus_monitor #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic sda_sync_o,
   output logic start_det_o,
   output logic stop_det_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_s;
   logic                   sda_s;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Synchronise the pads and keep the previous sample; reset to the idle-bus level so no edge appears out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign scl_rise_o  = scl_s & ~scl_prev_q;
   assign scl_fall_o  = ~scl_s & scl_prev_q;
   assign sda_sync_o  = sda_s;
   // SDA may only change with SCL high at START/STOP, so require SCL high in both samples.
   assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_color_receiver.sv
// rtl/i2c_color_receiver.sv - I2C target receiving five 16-bit colour words per frame
module i2c_color_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BYTES = colour_link_pkg::FRAME_BYTES
) (
   input  logic                        clk,
   input  logic                        rst_n,
   i2c_color_receiver_if.slave         bus,
   input  logic [6:0]                  own_address_i,
   input  logic                        endian_i,
   output logic [15:0]                 clear_data_o,
   output logic [15:0]                 red_data_o,
   output logic [15:0]                 green_data_o,
   output logic [15:0]                 blue_data_o,
   output logic [15:0]                 infrared_data_o,
   output logic                        data_valid_o,
   output logic                        frame_error_o,
   output logic                        busy_o
);
   import colour_link_pkg::*;

   localparam int IDX_W = $clog2(FRAME_BYTES + 1);

   logic             scl_rise, scl_fall, sda_sync, start_det, stop_det;
   rx_state_e        state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [6:0]       shift_q, shift_d;
   logic [7:0]       rx_byte;
   logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
   logic             ack_drive_q, ack_drive_d;
   logic [6:0]       own_addr_q, own_addr_d;
   logic             stage_we, abort, commit, in_frame;
   logic [7:0]       staging_q [FRAME_BYTES];
   logic [15:0]      words_q [WORDS];
   logic             data_valid_q, frame_error_q;

   i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
      .clk        (clk),
      .rst_n      (rst_n),
      .scl_i      (bus.scl),
      .sda_i      (bus.sda_in),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .sda_sync_o (sda_sync),
      .start_det_o(start_det),
      .stop_det_o (stop_det)
   );

   // A frame addressed to us is in progress once address bits have started arriving.
   assign in_frame = (state_q inside {ST_ADDR_ACK, ST_DATA, ST_DATA_ACK}) ||
                     (state_q == ST_ADDR && bit_cnt_q != 3'd0);

   // Next-state logic: bus conditions first, then per-state bit and ACK handling.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_idx_d  = byte_idx_q;
      ack_drive_d = ack_drive_q;
      own_addr_d  = own_addr_q;
      stage_we    = 1'b0;
      abort       = 1'b0;
      commit      = 1'b0;
      rx_byte     = {shift_q, sda_sync};
      if (start_det) begin
         // A START in WAIT_STOP also discards a complete but unterminated frame.
         abort       = in_frame || (state_q == ST_WAIT_STOP);
         own_addr_d  = own_address_i;
         state_d     = ST_ADDR;
         bit_cnt_d   = '0;
         byte_idx_d  = '0;
         ack_drive_d = 1'b0;
      end else if (stop_det) begin
         abort       = in_frame;
         commit      = (state_q == ST_WAIT_STOP);
         state_d     = ST_IDLE;
         bit_cnt_d   = '0;
         byte_idx_d  = '0;
         ack_drive_d = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_DATA: begin
               if (scl_rise) begin
                  shift_d   = rx_byte[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     if (state_q == ST_DATA) begin
                        stage_we = 1'b1;
                        state_d  = ST_DATA_ACK;
                     end else if (rx_byte[7:1] == own_addr_q && !rx_byte[0]) begin
                        state_d = ST_ADDR_ACK;
                     end else begin
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end
            ST_ADDR_ACK, ST_DATA_ACK: begin
               // First SCL fall starts the ACK drive, the second ends it.
               if (scl_fall) begin
                  if (!ack_drive_q) begin
                     ack_drive_d = 1'b1;
                  end else begin
                     ack_drive_d = 1'b0;
                     if (state_q == ST_ADDR_ACK) begin
                        state_d = ST_DATA;
                     end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = (byte_idx_d == IDX_W'(FRAME_BYTES)) ? ST_WAIT_STOP : ST_DATA;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         byte_idx_q  <= '0;
         ack_drive_q <= 1'b0;
         own_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         byte_idx_q  <= byte_idx_d;
         ack_drive_q <= ack_drive_d;
         own_addr_q  <= own_addr_d;
      end
   end

   // Staging bytes: cleared on abort, filled as each data byte completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FRAME_BYTES; i++) staging_q[i] <= '0;
      end else if (abort) begin
         for (int i = 0; i < FRAME_BYTES; i++) staging_q[i] <= '0;
      end else if (stage_we) begin
         staging_q[byte_idx_q] <= rx_byte;
      end
   end

   // Commit words on a well-formed STOP and register the status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < WORDS; k++) words_q[k] <= '0;
         data_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         data_valid_q  <= commit;
         frame_error_q <= abort;
         if (commit) begin
            for (int k = 0; k < WORDS; k++)
               words_q[k] <= assemble_word(staging_q[2*k], staging_q[2*k+1], endian_i);
         end
      end
   end

   assign bus.sda_oe      = ack_drive_q;
   assign busy_o          = (state_q != ST_IDLE);
   assign data_valid_o    = data_valid_q;
   assign frame_error_o   = frame_error_q;
   assign clear_data_o    = words_q[CH_CLEAR];
   assign red_data_o      = words_q[CH_RED];
   assign green_data_o    = words_q[CH_GREEN];
   assign blue_data_o     = words_q[CH_BLUE];
   assign infrared_data_o = words_q[CH_INFRARED];

endmodule

// File: tb/tb_i2c_color_receiver.sv
// tb/tb_i2c_color_receiver.sv - randomized self-checking bench for i2c_color_receiver
module tb_i2c_color_receiver;

   localparam int         Q   = 5;
   localparam int         NB  = 10;
   localparam logic [6:0] OWN = 7'h29;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl_drv = 1'b1;
   logic        sda_drv = 1'b1;
   logic [6:0]  own_address = OWN;
   logic        endian = 1'b1;
   logic [15:0] clear_data, red_data, green_data, blue_data, infrared_data;
   logic        data_valid, frame_error, busy;

   int checks = 0;
   int errors = 0;
   int dv_cnt = 0, fe_cnt = 0, both_cnt = 0;
   int exp_dv = 0, exp_fe = 0;
   logic [15:0] exp_words [5];
   logic [7:0]  tx [16];
   logic [7:0]  pat [10] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11, 8'h22};

   i2c_color_receiver_if bus_if ();
   assign bus_if.scl    = scl_drv;
   assign bus_if.sda_in = sda_drv & ~bus_if.sda_oe;

   i2c_color_receiver dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus_if.slave),
      .own_address_i  (own_address),
      .endian_i       (endian),
      .clear_data_o   (clear_data),
      .red_data_o     (red_data),
      .green_data_o   (green_data),
      .blue_data_o    (blue_data),
      .infrared_data_o(infrared_data),
      .data_valid_o   (data_valid),
      .frame_error_o  (frame_error),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (data_valid) dv_cnt++;
         if (frame_error) fe_cnt++;
         if (data_valid && frame_error) both_cnt++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic qwait();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_drv = 1'b1; qwait();
      scl_drv = 1'b1; qwait();
      sda_drv = 1'b0; qwait();
      scl_drv = 1'b0; qwait();
   endtask

   task automatic bus_stop();
      sda_drv = 1'b0; qwait();
      scl_drv = 1'b1; qwait();
      sda_drv = 1'b1; qwait();
   endtask

   task automatic send_bit(input logic b);
      sda_drv = b;    qwait();
      scl_drv = 1'b1; qwait(); qwait();
      scl_drv = 1'b0; qwait();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      sda_drv = 1'b1; qwait();
      scl_drv = 1'b1; qwait();
      acked = ~bus_if.sda_in;
      qwait();
      scl_drv = 1'b0; qwait();
   endtask

   // Word k is built from bytes 2k and 2k+1; endian picks which one is the high byte.
   function automatic logic [15:0] model_word(input int k, input logic e);
      int hi, lo;
      hi = e ? int'(tx[2*k]) : int'(tx[2*k+1]);
      lo = e ? int'(tx[2*k+1]) : int'(tx[2*k]);
      return 16'(hi * 256 + lo);
   endfunction

   task automatic check_outputs(input string tag);
      check_eq({tag, "_clear"}, clear_data, exp_words[0]);
      check_eq({tag, "_red"}, red_data, exp_words[1]);
      check_eq({tag, "_green"}, green_data, exp_words[2]);
      check_eq({tag, "_blue"}, blue_data, exp_words[3]);
      check_eq({tag, "_ir"}, infrared_data, exp_words[4]);
   endtask

   task automatic do_frame(input logic [6:0] a, input logic rw, input int n,
                           input logic e, input logic stop_end);
      logic acked, ours;
      ours   = (a == OWN) && !rw;
      endian = e;
      bus_start();
      check_eq("busy_after_start", busy, 1);
      send_byte({a, rw}, acked);
      check_eq("addr_ack", acked, ours);
      for (int i = 0; i < n; i++) begin
         send_byte(tx[i], acked);
         check_eq($sformatf("data_ack%0d", i), acked, ours && (i < NB));
      end
      if (stop_end) begin
         bus_stop();
         repeat (4) @(negedge clk);
         if (ours && n >= NB) begin
            exp_dv++;
            for (int k = 0; k < 5; k++) exp_words[k] = model_word(k, e);
         end else if (ours) begin
            exp_fe++;
         end
         check_eq("data_valid_count", dv_cnt, exp_dv);
         check_eq("frame_error_count", fe_cnt, exp_fe);
         check_eq("busy_after_stop", busy, 0);
         check_outputs("words");
      end else if (ours) begin
         exp_fe++;
      end
   endtask

   initial begin
      for (int k = 0; k < 5; k++) exp_words[k] = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_sda_oe", bus_if.sda_oe, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_dv", data_valid, 0);
      check_eq("rst_fe", frame_error, 0);
      check_outputs("rst");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < NB; i++) tx[i] = pat[i];
      do_frame(OWN, 1'b0, NB, 1'b1, 1'b1);
      check_eq("pat_clear_be", clear_data, 16'h1234);
      check_eq("pat_red_be", red_data, 16'h5678);
      check_eq("pat_green_be", green_data, 16'h9ABC);
      check_eq("pat_blue_be", blue_data, 16'hDEF0);
      check_eq("pat_ir_be", infrared_data, 16'h1122);

      do_frame(OWN, 1'b0, NB, 1'b0, 1'b1);
      check_eq("pat_clear_le", clear_data, 16'h3412);
      check_eq("pat_ir_le", infrared_data, 16'h2211);

      do_frame(7'h30, 1'b0, NB, 1'b1, 1'b1);

      for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
      do_frame(OWN, 1'b0, 4, 1'b1, 1'b1);
      do_frame(OWN, 1'b0, NB, 1'b1, 1'b1);

      for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
      do_frame(OWN, 1'b0, 6, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) tx[i] = 8'hAA;
      do_frame(OWN, 1'b0, NB, 1'b0, 1'b1);
      check_eq("aa_clear", clear_data, 16'hAAAA);
      check_eq("aa_ir", infrared_data, 16'hAAAA);

      for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
      do_frame(OWN, 1'b0, NB + 1, 1'b1, 1'b1);

      for (int f = 0; f < 10; f++) begin
         logic [6:0] a;
         logic       rw, se;
         int         n;
         a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : OWN;
         rw = ($urandom_range(0, 4) == 0);
         se = (f == 9) || ($urandom_range(0, 3) != 0);
         if (se && $urandom_range(0, 1) == 1) n = NB + $urandom_range(0, 2);
         else n = $urandom_range(0, NB - 1);
         for (int i = 0; i < 16; i++) tx[i] = 8'($urandom);
         do_frame(a, rw, n, 1'($urandom), se);
      end

      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : OWN[i-1]);
      check_eq("ack_before_rst", bus_if.sda_oe, 1);
      check_eq("busy_before_rst", busy, 1);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_sda_oe", bus_if.sda_oe, 0);
      check_eq("midrst_busy", busy, 0);
      for (int k = 0; k < 5; k++) exp_words[k] = '0;
      check_outputs("midrst");
      @(negedge clk);
      scl_drv = 1'b1;
      sda_drv = 1'b1;
      qwait();
      rst_n = 1'b1;
      qwait();
      check_eq("post_rst_busy", busy, 0);

      check_eq("dv_fe_overlap", both_cnt, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
